// File: rtl/module_opctrl.sv
// module_opctrl: calculator sequencing controller.
// Builds two 2-digit BCD operands from keypad events, launches the arithmetic
// unit with a start/done handshake and selects the display source.
// Optional build macro: TIMEOUT_EN adds a WAIT-state timeout that sets err.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ENTRY_A  | shifting digits into operand A, display A
// ENTRY_B  | shifting digits into operand B, display B
// START    | one-cycle alu_start pulse, operands frozen
// WAIT     | waiting for alu_done (or timeout), keys ignored
// SHOW     | displaying result; digit/clear starts a new entry
module module_opctrl #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int CNT_W          = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       alu_done,
  output logic [7:0] op_a,
  output logic [7:0] op_b,
  output logic       alu_start,
  output logic [1:0] disp_sel,
  output logic       busy,
  output logic       err
);

  typedef enum logic [4:0] {
    S_ENTRY_A = 5'b00001,
    S_ENTRY_B = 5'b00010,
    S_START   = 5'b00100,
    S_WAIT    = 5'b01000,
    S_SHOW    = 5'b10000
  } state_t;

  // The counter compare only works if the terminal value is representable.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_bad_timeout_cfg
    $error("module_opctrl: TIMEOUT_CYCLES must be in 1..2**CNT_W-1");
  end

  state_t     state_q, state_d;
  logic [7:0] op_a_q, op_a_d;
  logic [7:0] op_b_q, op_b_d;
  logic [1:0] cnt_q, cnt_d;
  logic       tmo_hit;

  logic key_digit, key_clear, key_enter;
  assign key_digit = key_valid && (key_code <= 4'd9);
  assign key_clear = key_valid && (key_code == 4'hA);
  assign key_enter = key_valid && (key_code == 4'hB);

`ifdef TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;

  // alu_done takes priority over a coincident terminal count.
  assign tmo_hit = (state_q == S_WAIT) && !alu_done && (tmo_q == TMO_LAST);
  assign err     = err_q;

  // Timeout counter and sticky error flag.
  always_comb begin
    tmo_d = tmo_q;
    err_d = err_q;
    case (state_q)
      S_ENTRY_A, S_ENTRY_B: ;
      S_START: tmo_d = '0;
      S_WAIT: begin
        tmo_d = tmo_q + 1'b1;
        if (tmo_hit) err_d = 1'b1;
      end
      S_SHOW:  if (key_digit || key_clear) err_d = 1'b0;
      default: begin
        tmo_d = '0;
        err_d = 1'b0;
      end
    endcase
  end

  // Timeout registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  // State and operand registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_ENTRY_A;
      op_a_q  <= 8'h00;
      op_b_q  <= 8'h00;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ENTRY_A: if (key_enter) state_d = S_ENTRY_B;
      S_ENTRY_B: if (key_enter) state_d = S_START;
      S_START:   state_d = S_WAIT;
      S_WAIT:    if (alu_done || tmo_hit) state_d = S_SHOW;
      S_SHOW:    if (key_digit || key_clear) state_d = S_ENTRY_A;
      default:   state_d = S_ENTRY_A;
    endcase
  end

  // Operand shift-in and digit count; operands are frozen from START to SHOW.
  always_comb begin
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    cnt_d  = cnt_q;
    case (state_q)
      S_ENTRY_A: begin
        if (key_digit) begin
          if (cnt_q < 2'd2) begin
            op_a_d = {op_a_q[3:0], key_code};
            cnt_d  = cnt_q + 2'd1;
          end
        end else if (key_clear) begin
          op_a_d = 8'h00;
          cnt_d  = 2'd0;
        end else if (key_enter) begin
          cnt_d = 2'd0;
        end
      end
      S_ENTRY_B: begin
        if (key_digit) begin
          if (cnt_q < 2'd2) begin
            op_b_d = {op_b_q[3:0], key_code};
            cnt_d  = cnt_q + 2'd1;
          end
        end else if (key_clear) begin
          op_b_d = 8'h00;
          cnt_d  = 2'd0;
        end
      end
      S_START, S_WAIT: ;
      S_SHOW: begin
        if (key_digit) begin
          op_a_d = {4'h0, key_code};
          op_b_d = 8'h00;
          cnt_d  = 2'd1;
        end else if (key_clear) begin
          op_a_d = 8'h00;
          op_b_d = 8'h00;
          cnt_d  = 2'd0;
        end
      end
      default: begin
        op_a_d = 8'h00;
        op_b_d = 8'h00;
        cnt_d  = 2'd0;
      end
    endcase
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    alu_start = 1'b0;
    busy      = 1'b0;
    disp_sel  = 2'd0;
    case (state_q)
      S_ENTRY_A: disp_sel = 2'd0;
      S_ENTRY_B: disp_sel = 2'd1;
      S_START: begin
        disp_sel  = 2'd1;
        busy      = 1'b1;
        alu_start = 1'b1;
      end
      S_WAIT: begin
        disp_sel = 2'd1;
        busy     = 1'b1;
      end
      S_SHOW:  disp_sel = 2'd2;
      default: disp_sel = 2'd0;
    endcase
  end

  assign op_a = op_a_q;
  assign op_b = op_b_q;

endmodule

// File: tb/tb_module_opctrl.sv
// Scoreboard bench for module_opctrl: stimulus pushes expected snapshots,
// start pulses and result displays into queues; a negedge monitor pops and
// compares whenever the DUT presents the matching event.
module tb_module_opctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       alu_done = 1'b0;
  logic [7:0] op_a, op_b;
  logic       alu_start, busy, err;
  logic [1:0] disp_sel;

  module_opctrl #(.TIMEOUT_CYCLES(8), .CNT_W(10)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .alu_done(alu_done), .op_a(op_a), .op_b(op_b), .alu_start(alu_start),
    .disp_sel(disp_sel), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] a, b;
    logic [1:0] ds;
    logic       bsy, st, er;
  } snap_t;
  typedef struct { logic [7:0] a, b; } ops_t;
  typedef struct { logic [7:0] a, b; logic er; } show_t;

  snap_t snap_q[$];
  ops_t  start_q[$];
  show_t show_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  task automatic snap(string nm, logic [7:0] a, logic [7:0] b, logic [1:0] ds,
                      logic bsy, logic st, logic er);
    snap_t s;
    s.name = nm; s.a = a; s.b = b; s.ds = ds; s.bsy = bsy; s.st = st; s.er = er;
    snap_q.push_back(s);
  endtask

  task automatic exp_start(logic [7:0] a, logic [7:0] b);
    ops_t o;
    o.a = a; o.b = b;
    start_q.push_back(o);
  endtask

  task automatic exp_show(logic [7:0] a, logic [7:0] b, logic er);
    show_t s;
    s.a = a; s.b = b; s.er = er;
    show_q.push_back(s);
  endtask

  task automatic key(logic [3:0] c);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic wait_start();
    int got;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (alu_start) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    chk("start_seen", got, 1);
  endtask

  task automatic pulse_done();
    alu_done = 1'b1;
    @(negedge clk);
    alu_done = 1'b0;
  endtask

  // Monitor: consumes expectations when the DUT presents the matching output.
  logic start_prev = 1'b0;
  logic [1:0] disp_prev = 2'd0;
  always @(negedge clk) begin
    snap_t s;
    ops_t  o;
    show_t w;
    if (snap_q.size() > 0) begin
      s = snap_q.pop_front();
      chk({s.name, ".op_a"}, op_a, s.a);
      chk({s.name, ".op_b"}, op_b, s.b);
      chk({s.name, ".disp_sel"}, disp_sel, s.ds);
      chk({s.name, ".busy"}, busy, s.bsy);
      chk({s.name, ".alu_start"}, alu_start, s.st);
      chk({s.name, ".err"}, err, s.er);
    end
    if (start_prev) chk("start_width", alu_start, 0);
    if (alu_start) begin
      chk("start_expected", int'(start_q.size() > 0), 1);
      if (start_q.size() > 0) begin
        o = start_q.pop_front();
        chk("start.op_a", op_a, o.a);
        chk("start.op_b", op_b, o.b);
        chk("start.busy", busy, 1);
        chk("start.disp_sel", disp_sel, 1);
      end
    end
    if (disp_sel == 2'd2 && disp_prev != 2'd2) begin
      chk("show_expected", int'(show_q.size() > 0), 1);
      if (show_q.size() > 0) begin
        w = show_q.pop_front();
        chk("show.op_a", op_a, w.a);
        chk("show.op_b", op_b, w.b);
        chk("show.err", err, w.er);
        chk("show.busy", busy, 0);
      end
    end
    start_prev <= alu_start;
    disp_prev  <= disp_sel;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    // Reset values
    repeat (2) @(negedge clk);
    snap("reset", 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Basic operation: 47 op 12
    key(4'h4); key(4'h7); key(4'hB);
    snap("a_entered", 8'h47, 8'h00, 2'd1, 1'b0, 1'b0, 1'b0);
    key(4'h1); key(4'h2);
    snap("b_entered", 8'h47, 8'h12, 2'd1, 1'b0, 1'b0, 1'b0);
    exp_start(8'h47, 8'h12);
    key(4'hB);
    wait_start();
    repeat (2) @(negedge clk);
    snap("wait_busy", 8'h47, 8'h12, 2'd1, 1'b1, 1'b0, 1'b0);
    exp_show(8'h47, 8'h12, 1'b0);
    repeat (3) @(negedge clk);
    pulse_done();

    // SHOW: enter ignored, digit starts new A with count 1
    key(4'hB);
    snap("show_enter", 8'h47, 8'h12, 2'd2, 1'b0, 1'b0, 1'b0);
    key(4'h6);
    snap("show_digit", 8'h06, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
    key(4'h9);
    snap("second_digit", 8'h69, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
    key(4'h3);
    snap("third_ignored", 8'h69, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
    key(4'hA);
    snap("clear_a", 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);

    // Saturation, clear, ignored codes, empty enter
    key(4'h9); key(4'h3); key(4'h8);
    snap("a_93", 8'h93, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
    key(4'hA);
    snap("a_cleared", 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
    key(4'hC); key(4'hF);
    snap("code_c_ignored", 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
    key(4'hB);
    snap("empty_enter", 8'h00, 8'h00, 2'd1, 1'b0, 1'b0, 1'b0);
    key(4'h5);
    snap("b_05", 8'h00, 8'h05, 2'd1, 1'b0, 1'b0, 1'b0);
    key(4'hA);
    snap("b_cleared", 8'h00, 8'h00, 2'd1, 1'b0, 1'b0, 1'b0);
    key(4'h8); key(4'h1);
    exp_start(8'h00, 8'h81);
    key(4'hB);
    wait_start();
    // done during START must be ignored
    alu_done = 1'b1;
    @(negedge clk);
    alu_done = 1'b0;
    key(4'h5); key(4'hA);
    snap("wait_keys_ignored", 8'h00, 8'h81, 2'd1, 1'b1, 1'b0, 1'b0);
    exp_show(8'h00, 8'h81, 1'b0);
    @(negedge clk);
    pulse_done();
    key(4'hA);
    snap("show_clear", 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in WAIT
    key(4'h2); key(4'hB); key(4'h3);
    exp_start(8'h02, 8'h03);
    key(4'hB);
    wait_start();
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    snap("async_reset", 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_start(8'h00, 8'h00);
    key(4'hB); key(4'hB);
    wait_start();

`ifdef TIMEOUT_EN
    exp_show(8'h00, 8'h00, 1'b1);
    cyc = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (disp_sel == 2'd2) begin
        cyc = i;
        break;
      end
    end
    chk("timeout_cycles", cyc, 9);
    key(4'hA);
    snap("timeout_clear", 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
`else
    cyc = 0;
    repeat (20) @(negedge clk);
    snap("wait_forever", 8'h00, 8'h00, 2'd1, 1'b1, 1'b0, 1'b0);
    exp_show(8'h00, 8'h00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    pulse_done();
    key(4'hA);
    snap("final_clear", 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
`endif

    repeat (4) @(negedge clk);
    chk("start_q_left", start_q.size(), 0);
    chk("show_q_left", show_q.size(), 0);
    chk("snap_q_left", snap_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/module_opctrl.md
Name: module_opctrl

Overview:
- Sequencing controller for the calculator datapath.
- Takes decoded keypad events and builds two 2-digit BCD operands (A, B) by digit shift-in.
- Launches the arithmetic unit with a start/done handshake, then selects what the display shows.
- Sits between the keypad decoder/debouncer and the arithmetic unit plus display mux.

Parameters:
- TIMEOUT_CYCLES, 1023, cycles spent in WAIT before timeout fires (used only when TIMEOUT_EN is defined).
- CNT_W, 10, width of the timeout counter; TIMEOUT_CYCLES must fit in CNT_W bits.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-low reset (rst=0 resets)
- key_valid  input  1  one-cycle pulse, key_code valid
- key_code  input  4  0x0-0x9 digit, 0xA clear, 0xB enter, 0xC-0xF ignored
- alu_done  input  1  one-cycle pulse from arithmetic unit, result ready
- op_a  output  8  operand A BCD, [7:4] tens, [3:0] units
- op_b  output  8  operand B BCD, same format
- alu_start  output  1  one-cycle start pulse to arithmetic unit
- disp_sel  output  2  0=show A, 1=show B, 2=show result, 3 unused
- busy  output  1  high in START and WAIT
- err  output  1  timeout flag

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-low.
- Reset values: state ENTRY_A, op_a=0x00, op_b=0x00, digit count=0, alu_start=0, disp_sel=0, busy=0, err=0, timeout counter=0.
- Key sampling: keys are sampled on the rising edge where key_valid=1. Register updates are visible the following cycle. key_valid=0 means no action.
- Digit shift-in, applied to the current operand:
  - units goes to tens, the new digit goes to units.
  - Digit count saturates at 2.
  - A third digit while count=2 is ignored; the operand is unchanged.
- Codes 0xC-0xF are ignored in every state.
- States (Moore outputs, one-hot encoding, 5 states):
  - ENTRY_A (disp_sel=0):
    - digit: shift into op_a.
    - clear: op_a=0x00, count=0.
    - enter: count=0, go to ENTRY_B. An enter with no digits keeps A=0x00.
  - ENTRY_B (disp_sel=1):
    - digit: shift into op_b.
    - clear: op_b=0x00, count=0.
    - enter: go to START.
  - START (disp_sel=1, busy=1, alu_start=1): exactly one cycle, then unconditionally go to WAIT. Timeout counter is cleared.
  - WAIT (disp_sel=1, busy=1):
    - all keys ignored.
    - alu_done=1: go to SHOW.
    - otherwise stay.
  - SHOW (disp_sel=2):
    - digit: op_a={4'h0,digit}, op_b=0x00, count=1, err=0, go to ENTRY_A.
    - clear: op_a=op_b=0x00, count=0, err=0, go to ENTRY_A.
    - enter: ignored.
- Operand stability: op_a and op_b are held stable from START until leaving SHOW.
- alu_done is sampled only in WAIT. A done pulse in any other state, including the START cycle, is ignored. The arithmetic unit must have ≥1 cycle latency.
- Illegal or unreached state encoding: recover to ENTRY_A with operands cleared.
- Reset mid-operation (any state, incl. WAIT): immediate return to reset values. alu_start deasserts asynchronously.

Optional Feature:
- Macro: TIMEOUT_EN.
- Defined:
  - In WAIT the counter increments every cycle.
  - If it reaches TIMEOUT_CYCLES with no alu_done: err=1 and go to SHOW.
  - err stays set until the next digit or clear key in SHOW, or reset.
  - If alu_done and the terminal count coincide, alu_done wins and err stays 0.
- Undefined: no counter is built; err is tied to 0 and WAIT waits indefinitely.

Test Plan:
- Reset, then keys 4,7,enter,1,2,enter, then alu_done 5 cycles after alu_start:
  - op_a=0x47, op_b=0x12.
  - alu_start high exactly 1 cycle.
  - busy high START through WAIT.
  - disp_sel goes 0→1→2.
- Keys 9,3,8 in ENTRY_A → op_a=0x93 (third digit ignored). Then clear → op_a=0x00, state still ENTRY_A.
- In WAIT press 5 and clear → no change to op_a/op_b/state. Pulse alu_done during START → ignored; a later alu_done in WAIT → SHOW.
- In SHOW press 6 → op_a=0x06, op_b=0x00, disp_sel=0. Pressing enter in SHOW → no change.
- Assert rst=0 mid-WAIT, asynchronous to clk → all outputs at reset values before the next edge; enter,enter afterwards gives op_a=op_b=0x00 and one start pulse.
- TIMEOUT_EN defined, TIMEOUT_CYCLES=8, no alu_done → err=1 and disp_sel=2 after 8 WAIT cycles; next clear → err=0, ENTRY_A.
